// File: rtl/cnt1_pkg.sv
// cnt1_var shared sizing constants, beat bundle and popcount-tree helpers.
// Tree helpers describe a granule stage followed by a pairwise adder tree.
package cnt1_pkg;

  localparam int MAX_VECTOR_WIDTH = 920;
  localparam int BUS_WIDTH        = 128;
  localparam int GRANULE_WIDTH    = 6;
  localparam int VEC_ID_WIDTH     = 16;
  localparam int CNT_WIDTH = $clog2(MAX_VECTOR_WIDTH + 1);
  localparam int LEN_WIDTH = $clog2(MAX_VECTOR_WIDTH + 1);
  localparam int SUM_WIDTH = $clog2(BUS_WIDTH + 1);

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  // node count of tree level k (level 0 = granule counts)
  function automatic int lvl_n(int ng, int k);
    int n;
    n = ng;
    for (int j = 0; j < k; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // flat offset of level k inside the node array
  function automatic int lvl_off(int ng, int k);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += lvl_n(ng, j);
    return o;
  endfunction

  function automatic int popcnt_delay(int width, int granule);
    return 1 + $clog2(ceil_div(width, granule));
  endfunction

  localparam int POP_DELAY = popcnt_delay(BUS_WIDTH, GRANULE_WIDTH);
  localparam int LAT       = POP_DELAY + 1;
  localparam int MAX_BEATS = ceil_div(MAX_VECTOR_WIDTH, BUS_WIDTH);
  localparam int IDX_WIDTH = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic                    vld;
    logic                    first;
    logic                    last;
    logic                    ulast;
    logic [VEC_ID_WIDTH-1:0] id;
    logic [BUS_WIDTH-1:0]    vec;
  } beat_t;

endpackage

// File: rtl/bit_cntr.sv
// Pipelined popcount: registered granule counts, then a registered adder tree.
// Ports: clk, rst, i_CntrEn (advance), i_Vector (in), o_Cnt (popcount out).
module bit_cntr
  import cnt1_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int GRANULE = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_CntrEn,
  input  logic [WIDTH-1:0]           i_Vector,
  output logic [$clog2(WIDTH+1)-1:0] o_Cnt
);

  localparam int SW    = $clog2(WIDTH + 1);
  localparam int NG    = ceil_div(WIDTH, GRANULE);
  localparam int DEPTH = popcnt_delay(WIDTH, GRANULE);
  localparam int NN    = lvl_off(NG, DEPTH);
  localparam int PW    = NG * GRANULE;

  logic [PW-1:0] pad;
  logic [SW-1:0] node [NN];

  assign pad   = PW'(i_Vector);
  assign o_Cnt = node[NN-1];

  function automatic logic [SW-1:0] gran_cnt(
    logic [GRANULE-1:0] g
  );
    logic [SW-1:0] c;
    c = '0;
    for (int b = 0; b < GRANULE; b++)
      c = c + SW'(g[b]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NN; i++)
        node[i] <= '0;
    end else if (i_CntrEn) begin
      for (int g = 0; g < NG; g++)
        node[g] <= gran_cnt(pad[g*GRANULE +: GRANULE]);
      for (int k = 1; k < DEPTH; k++) begin
        for (int i = 0; i < NG; i++) begin
          if (i < lvl_n(NG, k)) begin
            // odd node at the end of a level passes through alone
            node[lvl_off(NG, k) + i] <=
              node[lvl_off(NG, k-1) + 2*i] +
              ((2*i + 1 < lvl_n(NG, k-1)) ?
                node[lvl_off(NG, k-1) + 2*i + 1] : '0);
          end
        end
      end
    end
  end

endmodule

// File: rtl/cnt1_var.sv
// Streaming variable-length popcount with beat pass-through and backpressure.
// Ports: cfg_VecWidth, up_* (in beat), dn_* (out beat, dn_Cnt/dn_CntNew).
module cnt1_var
  import cnt1_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEN_WIDTH-1:0]    cfg_VecWidth,
  input  logic [BUS_WIDTH-1:0]    up_Vector,
  input  logic [VEC_ID_WIDTH-1:0] up_ID,
  input  logic                    up_Valid,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [BUS_WIDTH-1:0]    dn_SubVector,
  output logic [VEC_ID_WIDTH-1:0] dn_ID,
  output logic                    dn_Valid,
  output logic                    dn_Last,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic                    dn_CntNew,
  input  logic                    dn_Ready
);

  localparam int LS  = POP_DELAY - 1;
  localparam int LW1 = LEN_WIDTH + 1;

  logic                 en;
  logic                 take;
  logic [LEN_WIDTH-1:0] len_cfg;
  logic [LW1-1:0]       len_rnd;
  logic [IDX_WIDTH-1:0] nb_cfg;
  logic [LEN_WIDTH-1:0] tail_cfg;
  logic [IDX_WIDTH-1:0] idx;
  logic [IDX_WIDTH-1:0] nb_q;
  logic [LEN_WIDTH-1:0] tail_q;
  logic [IDX_WIDTH-1:0] cur_nb;
  logic [LEN_WIDTH-1:0] cur_tail;
  logic                 is_first;
  logic                 is_last;
  logic [BUS_WIDTH-1:0] masked;
  logic [SUM_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] nxt_acc;
  logic                 out_last;
  beat_t                inb;
  beat_t                pipe [POP_DELAY];

  assign en       = dn_Ready || !dn_Valid;
  assign up_Ready = en;
  assign take     = up_Valid && en;

  always_comb begin
    len_cfg = cfg_VecWidth;
    if (cfg_VecWidth == '0 ||
        cfg_VecWidth > LEN_WIDTH'(MAX_VECTOR_WIDTH))
      len_cfg = LEN_WIDTH'(MAX_VECTOR_WIDTH);
  end

  assign len_rnd  = {1'b0, len_cfg} + LW1'(BUS_WIDTH - 1);
  assign nb_cfg   = IDX_WIDTH'(len_rnd / LW1'(BUS_WIDTH));
  assign tail_cfg = len_cfg -
    LEN_WIDTH'(nb_cfg - 1'b1) * LEN_WIDTH'(BUS_WIDTH);

  // beat 0 uses the live cfg; later beats use the latched framing
  assign is_first = idx == '0;
  assign cur_nb   = is_first ? nb_cfg : nb_q;
  assign cur_tail = is_first ? tail_cfg : tail_q;
  assign is_last  = idx == cur_nb - 1'b1;

  always_comb begin
    masked = up_Vector;
    if (is_last) begin
      for (int b = 0; b < BUS_WIDTH; b++)
        if (b >= int'(cur_tail)) masked[b] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      nb_q   <= '0;
      tail_q <= '0;
    end else if (take) begin
      idx <= is_last ? '0 : idx + 1'b1;
      if (is_first) begin
        nb_q   <= nb_cfg;
        tail_q <= tail_cfg;
      end
    end
  end

  bit_cntr #(
    .WIDTH   (BUS_WIDTH),
    .GRANULE (GRANULE_WIDTH)
  ) u_pop (
    .clk      (clk),
    .rst      (rst),
    .i_CntrEn (en),
    .i_Vector (masked),
    .o_Cnt    (sum)
  );

  assign inb = '{
    vld:   up_Valid,
    first: is_first,
    last:  is_last,
    ulast: up_Last,
    id:    up_ID,
    vec:   up_Vector
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < POP_DELAY; i++)
        pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= inb;
      for (int i = 1; i < POP_DELAY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign nxt_acc = pipe[LS].first ? CNT_WIDTH'(sum)
                                  : acc + CNT_WIDTH'(sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_Valid     <= 1'b0;
      dn_Last      <= 1'b0;
      out_last     <= 1'b0;
      dn_Cnt       <= '0;
      acc          <= '0;
      dn_SubVector <= '0;
      dn_ID        <= '0;
    end else if (en) begin
      dn_Valid     <= pipe[LS].vld;
      dn_Last      <= pipe[LS].ulast;
      out_last     <= pipe[LS].last;
      dn_SubVector <= pipe[LS].vec;
      dn_ID        <= pipe[LS].id;
      if (pipe[LS].vld) begin
        acc <= nxt_acc;
        if (pipe[LS].last) dn_Cnt <= nxt_acc;
      end
    end
  end

  assign dn_CntNew = dn_Valid && out_last;

endmodule

// File: tb/tb_cnt1_var.sv
// Scoreboard bench for cnt1_var: driver queues expected beats,
// a negedge monitor pops and compares each transferred output beat.
module tb_cnt1_var;
  import cnt1_pkg::*;

  localparam int LATX = 7;

  typedef struct {
    logic [127:0] vec;
    logic [15:0]  id;
    logic         ulast;
    logic         cnew;
    logic [9:0]   cnt;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   cfg_VecWidth = 10'd920;
  logic [127:0] up_Vector = '0;
  logic [15:0]  up_ID = '0;
  logic         up_Valid = 1'b0;
  logic         up_Last = 1'b0;
  logic         up_Ready;
  logic [127:0] dn_SubVector;
  logic [15:0]  dn_ID;
  logic         dn_Valid;
  logic         dn_Last;
  logic [9:0]   dn_Cnt;
  logic         dn_CntNew;
  logic         dn_Ready = 1'b1;

  exp_t       q[$];
  exp_t       mon_e;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         rdy_rand = 1'b0;
  bit         lat_chk = 1'b0;
  int         stall_seen = 0;
  logic [9:0] last_cnt = '0;
  int         cfgs[5] = '{920, 300, 128, 1, 700};

  cnt1_var dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_VecWidth (cfg_VecWidth),
    .up_Vector    (up_Vector),
    .up_ID        (up_ID),
    .up_Valid     (up_Valid),
    .up_Last      (up_Last),
    .up_Ready     (up_Ready),
    .dn_SubVector (dn_SubVector),
    .dn_ID        (dn_ID),
    .dn_Valid     (dn_Valid),
    .dn_Last      (dn_Last),
    .dn_Cnt       (dn_Cnt),
    .dn_CntNew    (dn_CntNew),
    .dn_Ready     (dn_Ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    dn_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && dn_Valid && dn_Ready) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_beat: got id %h expected none", dn_ID);
      end else begin
        mon_e = q.pop_front();
        chk("data", dn_SubVector, mon_e.vec);
        chk("id", 128'(dn_ID), 128'(mon_e.id));
        chk("last", 128'(dn_Last), 128'(mon_e.ulast));
        chk("cnt_new", 128'(dn_CntNew), 128'(mon_e.cnew));
        chk("cnt", 128'(dn_Cnt), 128'(mon_e.cnt));
        if (lat_chk)
          chk("latency", 128'(cyc - mon_e.cyc), 128'(LATX));
      end
    end
  end

  // drives the first nsend beats of one vector; cfg_late from beat 4 on
  task automatic send_vec(input int cfg, input int cfg_late,
                          input int mode, input logic [15:0] id,
                          input int nsend);
    int l, n, t, acc, g;
    logic [127:0] d, m;
    exp_t e;
    l = (cfg == 0 || cfg > 920) ? 920 : cfg;
    n = (l + 127) / 128;
    t = l - (n - 1) * 128;
    acc = 0;
    for (int b = 0; b < n && b < nsend; b++) begin
      case (mode)
        0: d = '1;
        1: d = {4{32'h5555_5555}};
        default: d = {$urandom, $urandom, $urandom, $urandom};
      endcase
      m = d;
      if (b == n - 1)
        for (int i = t; i < 128; i++) m[i] = 1'b0;
      acc += $countones(m);
      cfg_VecWidth = 10'(b >= 4 ? cfg_late : cfg);
      up_Vector = d;
      up_ID = id;
      up_Last = (b == n - 1) && id[0];
      up_Valid = 1'b1;
      @(negedge clk);
      g = 0;
      while (!up_Ready && g < 200) begin
        g++;
        @(negedge clk);
      end
      if (g > 0) stall_seen++;
      if (!up_Ready) begin
        n_chk++;
        $display("FAIL up_ready_timeout: got 0 expected 1");
      end
      e.vec = d;
      e.id = id;
      e.ulast = up_Last;
      e.cnew = (b == n - 1);
      if (b == n - 1) last_cnt = 10'(acc);
      e.cnt = last_cnt;
      e.cyc = cyc;
      q.push_back(e);
      @(posedge clk);
      #1;
      up_Valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", q.size());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(dn_Valid), 128'(0));
    chk("rst_cntnew", 128'(dn_CntNew), 128'(0));
    chk("rst_cnt", 128'(dn_Cnt), 128'(0));
    chk("rst_last", 128'(dn_Last), 128'(0));
    chk("rst_ready", 128'(up_Ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send_vec(920, 920, 0, 16'h0001, 8);
    drain();

    stall_seen = 0;
    for (int i = 0; i < 3; i++)
      send_vec(920, 920, 1, 16'(16'h0010 + i), 8);
    drain();
    chk("up_ready_const", 128'(stall_seen), 128'(0));

    for (int i = 0; i < 6; i++)
      send_vec(128, 128, 2, 16'(16'h0100 + i), 8);
    for (int i = 0; i < 6; i++)
      send_vec(1, 1, 2, 16'(16'h0200 + i), 8);
    drain();

    send_vec(920, 256, 0, 16'h0301, 8);
    send_vec(256, 256, 2, 16'h0302, 8);
    send_vec(0, 0, 0, 16'h0303, 8);
    drain();

    lat_chk = 1'b0;
    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++)
      send_vec(cfgs[i % 5], cfgs[i % 5], 2, 16'(16'h0400 + i), 8);
    drain();
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    send_vec(920, 920, 0, 16'h0501, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(dn_Valid), 128'(0));
    chk("mid_rst_cntnew", 128'(dn_CntNew), 128'(0));
    chk("mid_rst_cnt", 128'(dn_Cnt), 128'(0));
    chk("mid_rst_last", 128'(dn_Last), 128'(0));
    q.delete();
    last_cnt = '0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_vec(920, 920, 1, 16'h0502, 8);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cnt1_var.md
Name: cnt1_var

Overview:
- Streaming popcount stage for the fingerprint pipeline; successor to the fixed-length counter.
- Accepts vectors as BUS_WIDTH-bit beats and emits each beat unchanged, with ID and Last, after a fixed latency.
- Vector length is runtime-configurable up to MAX_VECTOR_WIDTH. Tail bits of the final beat are masked out of the count.
- Full valid/ready handshake: output bubbles are absorbed instead of stalling upstream.

Parameters:
MAX_VECTOR_WIDTH, 920, largest supported vector length in bits
BUS_WIDTH, 128, beat width in bits
GRANULE_WIDTH, 6, LUT granule of the popcount tree
VEC_ID_WIDTH, 16, ID field width
CNT_WIDTH, $clog2(MAX_VECTOR_WIDTH+1), count width; holds an all-ones vector without overflow
LEN_WIDTH, $clog2(MAX_VECTOR_WIDTH+1), width of cfg_VecWidth

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_VecWidth  in  LEN_WIDTH  vector length in bits; sampled on beat 0 of each vector
up_Vector  in  BUS_WIDTH  input beat
up_ID  in  VEC_ID_WIDTH  vector ID
up_Valid  in  1  beat valid
up_Last  in  1  end-of-stream marker, passed through unchanged
up_Ready  out  1  beat accepted when up_Valid && up_Ready
dn_SubVector  out  BUS_WIDTH  delayed beat, unmasked
dn_ID  out  VEC_ID_WIDTH  delayed ID
dn_Valid  out  1  output beat valid
dn_Last  out  1  delayed up_Last
dn_Cnt  out  CNT_WIDTH  popcount of the completed vector
dn_CntNew  out  1  high on the final beat of a vector; dn_Cnt is valid with it
dn_Ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync release):
  - All stage valids, beat counter, accumulator and latched length clear.
  - dn_Valid=0, dn_CntNew=0, dn_Cnt=0, dn_Last=0.
  - dn_SubVector and dn_ID are don't-care while dn_Valid=0.
- Pipeline:
  - LAT = POP_DELAY+1 stages, where POP_DELAY is the popcount tree depth from the package function.
  - Advance enable en = dn_Ready || !dn_Valid.
  - up_Ready = en (combinational).
  - With no stall, a beat accepted at cycle t appears on the outputs at t+LAT.
  - While en=0, every stage holds, including the accumulator and beat counter.
  - Invalid (bubble) stages shift like data; no beat is ever dropped or duplicated.
- Length latch:
  - On an accepted beat with index 0, latch L = cfg_VecWidth.
  - L==0 or L>MAX_VECTOR_WIDTH is clamped to MAX_VECTOR_WIDTH.
  - N = ceil(L/BUS_WIDTH) is computed once at latch time.
  - cfg changes mid-vector are ignored until the next beat 0.
- Beat counter:
  - Increments per accepted beat and wraps to 0 after index N-1.
  - Each beat carries tag bits isFirst (idx==0) and isLast (idx==N-1) down the pipeline.
  - Tail valid-bit count T = L-(N-1)*BUS_WIDTH, range 1..BUS_WIDTH.
- Tail mask:
  - On the isLast beat, bits [BUS_WIDTH-1:T] are zeroed on the popcount input only.
  - Other beats are counted in full.
- Accumulator (final stage):
  - isFirst && isLast: acc = sum.
  - isFirst: acc = sum.
  - Otherwise: acc = acc + sum. Zero-extend sum; it is $clog2(BUS_WIDTH+1) bits wide.
  - dn_Cnt is the registered acc. It updates with the isLast beat and holds until the next isLast beat.
- dn_CntNew = dn_Valid && isLast tag of the output stage.
- Single-beat vectors (N=1) raise dn_CntNew on every beat.
- up_Last does not affect framing.

Decomposition:
- Package cnt1_pkg:
  - function popcnt_delay(width, granule), giving POP_DELAY.
  - function ceil_div.
  - localparam SUM_WIDTH = $clog2(BUS_WIDTH+1).
- Sub-module: the existing bit_cntr, pipelined popcount with enable. Instantiate with i_CntrEn=en and fed the masked beat.
- Framing logic, tag shift registers and the accumulator stay in cnt1_var.

Test Plan:
- cfg=920, 8 all-ones beats, dn_Ready=1 -> dn_CntNew only on beat 8, dn_Cnt=920 (tail T=24 counted, 104 bits masked); first output at t+LAT.
- Back-to-back vectors with pattern 0x55.., cfg=920 -> dn_Cnt=460 each; dn_CntNew every 8th beat; up_Ready constantly 1.
- Random dn_Ready toggling, 20 vectors with random data -> order and IDs preserved, no loss or duplication, counts match the model.
- cfg=128 with random data -> dn_CntNew on every beat, dn_Cnt = popcount(beat); cfg=1 -> dn_Cnt=bit0 of each beat.
- rst pulsed after 3 beats of a vector -> all outputs 0 immediately; the next vector counts correctly from beat 0.
- cfg changed from 920 to 256 on beat 4 -> current vector keeps N=8; the next vector uses N=2. cfg=0 -> behaves as 920.
